mask_iota_seq: RTL

Element sequencer that feeds `iota_res` and `offset` to the lane mask unit for `viota.m` and `vid.v`. It walks element indices from `vstart` to `vl-1`, one element per accepted handshake, and fetches 32-bit mask words from the mask register read path. For iota it keeps a running prefix count of set source-mask bits. It sits between vector decode/issue and the mask unit inside each `rv32v` lane.

---
 rtl/mask_iota_seq.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mask_iota_seq.sv
// mask_iota_seq: element sequencer feeding iota_res/offset to the lane mask unit for viota.m and vid.v.
// Define MASK_IOTA_SEQ_PREFETCH_EN to add a one-word mask prefetch buffer (zero-bubble word boundaries).
module mask_iota_seq #(
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             op_iota,
    input  logic             vm,
    input  logic [IDX_W:0]   vl,
    input  logic [IDX_W-1:0] vstart,
    output logic             word_req,
    output logic [IDX_W-6:0] word_idx,
    input  logic             word_valid,
    input  logic [31:0]      src_word,
    input  logic [31:0]      v0_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_active,
    output logic [31:0]      iota_res,
    output logic [31:0]      offset,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [1:0]       S_IDLE  = 2'd0;
    localparam logic [1:0]       S_FETCH = 2'd1;
    localparam logic [1:0]       S_RUN   = 2'd2;
    localparam logic [1:0]       S_DONE  = 2'd3;
    localparam logic [IDX_W:0]   ONE_V   = 1;
    localparam logic [IDX_W-1:0] ONE_I   = 1;

    logic [1:0]       state_q, state_d;
    logic             op_iota_q, op_iota_d, vm_q, vm_d, err_q, err_d;
    logic [IDX_W:0]   vl_q, vl_d, cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [31:0]      src_q, src_d, v0_q, v0_d;
    logic             run, need_fetch, act, last, hs;

    assign run        = state_q == S_RUN;
    // vid.v with vm=1 never looks at mask data, so it skips fetching entirely
    assign need_fetch = op_iota_q | ~vm_q;
    assign act        = vm_q | v0_q[idx_q[4:0]];
    assign last       = {1'b0, idx_q} == (vl_q - ONE_V);
    assign hs         = run & out_ready;
    assign idx_inc    = idx_q + ONE_I;

`ifdef MASK_IOTA_SEQ_PREFETCH_EN
    localparam logic [IDX_W-4:0] ONE_W = 1;
    logic             pf_vld_q, pf_vld_d;
    logic [31:0]      pf_src_q, pf_src_d, pf_v0_q, pf_v0_d;
    logic [IDX_W-4:0] nxt_word;
    logic             pf_req, pf_take;

    // request the following word only if it holds at least one element below vl
    assign nxt_word = {1'b0, idx_q[IDX_W-1:5]} + ONE_W;
    assign pf_req   = run & need_fetch & ~pf_vld_q & ({nxt_word, 5'b0} < vl_q);
    assign pf_take  = pf_req & word_valid;
    assign word_req = (state_q == S_FETCH) | pf_req;
    assign word_idx = run ? nxt_word[IDX_W-6:0] : idx_q[IDX_W-1:5];
`else
    assign word_req = state_q == S_FETCH;
    assign word_idx = idx_q[IDX_W-1:5];
`endif

    assign out_valid  = run;
    assign out_idx    = idx_q;
    assign out_active = run & act;
    assign out_last   = run & last;
    assign iota_res   = {{(31-IDX_W){1'b0}}, cnt_q};
    assign offset     = {{(32-IDX_W){1'b0}}, idx_q};
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DONE;
    assign err        = err_q;

    always_comb begin
        state_d   = state_q;
        op_iota_d = op_iota_q;
        vm_d      = vm_q;
        vl_d      = vl_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        src_d     = src_q;
        v0_d      = v0_q;
        err_d     = 1'b0;
`ifdef MASK_IOTA_SEQ_PREFETCH_EN
        pf_vld_d  = pf_vld_q;
        pf_src_d  = pf_src_q;
        pf_v0_d   = pf_v0_q;
        if (pf_take) begin
            pf_vld_d = 1'b1;
            pf_src_d = src_word;
            pf_v0_d  = v0_word;
        end
`endif
        case (state_q)
            S_IDLE: if (start) begin
                op_iota_d = op_iota;
                vm_d      = vm;
                vl_d      = vl;
                idx_d     = vstart;
                cnt_d     = '0;
`ifdef MASK_IOTA_SEQ_PREFETCH_EN
                pf_vld_d  = 1'b0;
`endif
                // a prefix count cannot resume mid-vector, so iota with vstart!=0 is rejected
                if (op_iota && vstart != '0)      err_d   = 1'b1;
                else if ({1'b0, vstart} >= vl)    state_d = S_DONE;
                else if (!op_iota && vm)          state_d = S_RUN;
                else                              state_d = S_FETCH;
            end
            S_FETCH: if (word_valid) begin
                src_d   = src_word;
                v0_d    = v0_word;
                state_d = S_RUN;
            end
            S_RUN: if (hs) begin
                if (op_iota_q && act && src_q[idx_q[4:0]]) cnt_d = cnt_q + ONE_V;
                idx_d = idx_inc;
                if (last) begin
                    state_d = S_DONE;
                end else if (idx_inc[4:0] == 5'd0 && need_fetch) begin
`ifdef MASK_IOTA_SEQ_PREFETCH_EN
                    if (pf_vld_q) begin
                        src_d    = pf_src_q;
                        v0_d     = pf_v0_q;
                        pf_vld_d = 1'b0;
                    end else if (pf_take) begin
                        src_d    = src_word;
                        v0_d     = v0_word;
                        pf_vld_d = 1'b0;
                    end else begin
                        state_d  = S_FETCH;
                    end
`else
                    state_d = S_FETCH;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            op_iota_q <= 1'b0;
            vm_q      <= 1'b0;
            vl_q      <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            src_q     <= '0;
            v0_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_iota_q <= op_iota_d;
            vm_q      <= vm_d;
            vl_q      <= vl_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            v0_q      <= v0_d;
            err_q     <= err_d;
        end
    end

`ifdef MASK_IOTA_SEQ_PREFETCH_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            pf_vld_q <= 1'b0;
            pf_src_q <= '0;
            pf_v0_q  <= '0;
        end else begin
            pf_vld_q <= pf_vld_d;
            pf_src_q <= pf_src_d;
            pf_v0_q  <= pf_v0_d;
        end
    end
`endif

endmodule
